// File: rtl/ps2_space_key.sv
// PS/2 keyboard receiver that tracks whether the space bar is held.
// Exposes each correctly received byte and a frame-error strobe for debug.
module ps2_space_key #(
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       space,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_NORMAL, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] filt;
  logic                  fclk;
  logic                  din;
  logic                  fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt      <= '1;
      fclk      <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt      <= {filt[FILTER_LEN-2:0], clk_sync[1]};
      if (&filt)
        fclk <= 1'b1;
      else if (~|filt)
        fclk <= 1'b0;
    end
  end

  // Combinational so the edge is seen the cycle the filter fills with zeros.
  assign fall = fclk & ~|filt;
  assign din  = data_sync[1];

  // ---------------- receiver ----------------
  rx_state_t      rx_state, rx_nxt;
  logic [2:0]     bit_cnt, bit_nxt;
  logic [7:0]     shreg, sh_nxt;
  logic           par_bit, par_nxt;
  logic [CW-1:0]  tmo_cnt;
  logic           timeout;
  logic           bv_nxt, fe_nxt;
  logic [7:0]     rxb_nxt;

  assign timeout = (rx_state != RX_IDLE) && !fall &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    rx_nxt  = rx_state;
    bit_nxt = bit_cnt;
    sh_nxt  = shreg;
    par_nxt = par_bit;
    rxb_nxt = rx_byte;
    bv_nxt  = 1'b0;
    fe_nxt  = 1'b0;
    if (timeout) begin
      rx_nxt = RX_IDLE;
      fe_nxt = 1'b1;
    end else if (fall) begin
      unique case (rx_state)
        RX_IDLE: begin
          if (!din) begin
            rx_nxt  = RX_DATA;
            bit_nxt = 3'd0;
          end
        end
        RX_DATA: begin
          sh_nxt  = {din, shreg[7:1]};
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            rx_nxt = RX_PARITY;
        end
        RX_PARITY: begin
          par_nxt = din;
          rx_nxt  = RX_STOP;
        end
        RX_STOP: begin
          // Odd parity over data+parity, stop bit must be high.
          if (din && ^{shreg, par_bit}) begin
            rxb_nxt = shreg;
            bv_nxt  = 1'b1;
          end else begin
            fe_nxt  = 1'b1;
          end
          rx_nxt = RX_IDLE;
        end
        default: rx_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= sh_nxt;
      par_bit    <= par_nxt;
      rx_byte    <= rxb_nxt;
      byte_valid <= bv_nxt;
      frame_err  <= fe_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fall || rx_state == RX_IDLE)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // ---------------- scan-code decoder ----------------
  dec_state_t dec_state, dec_nxt;
  logic       space_nxt;

  always_comb begin
    dec_nxt   = dec_state;
    space_nxt = space;
    if (frame_err) begin
      dec_nxt = DEC_NORMAL;
    end else if (byte_valid) begin
      unique case (dec_state)
        DEC_NORMAL: begin
          if (rx_byte == SC_BREAK)
            dec_nxt = DEC_BRK;
          else if (rx_byte == SC_EXT)
            dec_nxt = DEC_EXT;
          else if (rx_byte == SC_SPACE)
            space_nxt = 1'b1;
        end
        DEC_BRK: begin
          if (rx_byte == SC_SPACE)
            space_nxt = 1'b0;
          dec_nxt = DEC_NORMAL;
        end
        DEC_EXT:     dec_nxt = (rx_byte == SC_BREAK) ? DEC_EXT_BRK : DEC_NORMAL;
        DEC_EXT_BRK: dec_nxt = DEC_NORMAL;
        default:     dec_nxt = DEC_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_state <= DEC_NORMAL;
      space     <= 1'b0;
    end else begin
      dec_state <= dec_nxt;
      space     <= space_nxt;
    end
  end

endmodule
